// File: rtl/pirdsp_mult_pkg.sv
// Shared constants and the fixed-width result payload for the PIRDSP multiplier scheduler.
package pirdsp_mult_pkg;

   localparam logic MODE_27X18   = 1'b0;
   localparam logic MODE_SUM_9X9 = 1'b1;

   localparam int OPND_W  = 54;
   localparam int RES_W   = 45;
   localparam int CARRY_W = 4;

   // Result fields captured from the multiplier. The {id, tag} wrapper lives in the
   // top because the tag width is a top-level parameter.
   typedef struct packed {
      logic [RES_W-1:0]   res0;
      logic [RES_W-1:0]   res1;
      logic [CARRY_W-1:0] carry;
   } resp_data_t;

endpackage

// File: rtl/pirdsp_resp_fifo.sv
// Synchronous show-ahead FIFO: head is valid whenever not_empty, with no push-to-head bypass.
module pirdsp_resp_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [7:0]
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  entry_t                   push_data,
   input  logic                     pop,
   output entry_t                   head,
   output logic                     not_empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic            do_pop;

   assign do_pop    = pop & (count_reg != '0);
   assign not_empty = (count_reg != '0);
   assign count     = count_reg;
   assign head      = mem[rd_ptr_reg];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Upstream credit logic must never push into a full FIFO.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         assert (count_reg < FULL_CNT);
      end
   end

endmodule

// File: rtl/pirdsp_mult_scheduler.sv
// Two-port round-robin scheduler for one shared PIRDSP multiplier with fixed-latency
// result capture and a credit-protected, tagged response FIFO.
module pirdsp_mult_scheduler
   import pirdsp_mult_pkg::*;
#(
   parameter int MULT_LAT   = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          s0_valid,
   output logic                          s0_ready,
   input  logic [OPND_W-1:0]             s0_a,
   input  logic [OPND_W-1:0]             s0_b,
   input  logic                          s0_a_sign,
   input  logic                          s0_b_sign,
   input  logic                          s0_mode,
   input  logic [TAG_W-1:0]              s0_tag,
   input  logic                          s1_valid,
   output logic                          s1_ready,
   input  logic [OPND_W-1:0]             s1_a,
   input  logic [OPND_W-1:0]             s1_b,
   input  logic                          s1_a_sign,
   input  logic                          s1_b_sign,
   input  logic                          s1_mode,
   input  logic [TAG_W-1:0]              s1_tag,
   output logic [OPND_W-1:0]             m_a,
   output logic [OPND_W-1:0]             m_b,
   output logic                          m_a_sign,
   output logic                          m_b_sign,
   output logic                          m_mode,
   input  logic [RES_W-1:0]              m_result_0,
   input  logic [RES_W-1:0]              m_result_1,
   input  logic [CARRY_W-1:0]            m_result_carry,
   output logic                          r_valid,
   input  logic                          r_ready,
   output logic                          r_id,
   output logic [TAG_W-1:0]              r_tag,
   output logic [RES_W-1:0]              r_result_0,
   output logic [RES_W-1:0]              r_result_1,
   output logic [CARRY_W-1:0]            r_carry,
   output logic [$clog2(FIFO_DEPTH):0]   inflight
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic             id;
      logic [TAG_W-1:0] tag;
      resp_data_t       data;
   } resp_entry_t;

   logic [CW-1:0]    inflight_reg, inflight_next;
   logic             last_grant_reg;
   logic             grant0, grant1, credit_ok, issue, issue_id, pop;

   logic             pipe_valid_reg [MULT_LAT];
   logic             pipe_id_reg    [MULT_LAT];
   logic [TAG_W-1:0] pipe_tag_reg   [MULT_LAT];

   logic             cap_valid_reg;
   resp_entry_t      cap_entry_reg;
   resp_entry_t      head;
   logic [CW-1:0]    fifo_count;

   // Every op in the latency pipe, capture stage or FIFO holds a credit, so a push always fits.
   assign credit_ok = (inflight_reg < CW'(FIFO_DEPTH));

   // Round robin: a lone requester wins; on contention the port not granted last wins.
   always_comb begin
      grant0 = s0_valid & (~s1_valid | last_grant_reg);
      grant1 = s1_valid & (~s0_valid | ~last_grant_reg);
   end

   assign s0_ready = grant0 & credit_ok & ~reset;
   assign s1_ready = grant1 & credit_ok & ~reset;
   assign issue    = s0_ready | s1_ready;
   assign issue_id = s1_ready;
   assign pop      = r_valid & r_ready;
   assign inflight = inflight_reg;

   // Credit counter next value: issue adds, pop removes, both together cancel.
   always_comb begin
      inflight_next = inflight_reg;
      case ({issue, pop})
         2'b10:   inflight_next = inflight_reg + 1'b1;
         2'b01:   inflight_next = inflight_reg - 1'b1;
         default: inflight_next = inflight_reg;
      endcase
   end

   // Credit counter and round-robin pointer (reset favours port 0).
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_reg   <= '0;
         last_grant_reg <= 1'b1;
      end else begin
         inflight_reg <= inflight_next;
         if (issue) last_grant_reg <= issue_id;
      end
   end

   // Registered multiplier operands; they hold between issues.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_a      <= '0;
         m_b      <= '0;
         m_a_sign <= 1'b0;
         m_b_sign <= 1'b0;
         m_mode   <= MODE_27X18;
      end else if (issue) begin
         m_a      <= issue_id ? s1_a      : s0_a;
         m_b      <= issue_id ? s1_b      : s0_b;
         m_a_sign <= issue_id ? s1_a_sign : s0_a_sign;
         m_b_sign <= issue_id ? s1_b_sign : s0_b_sign;
         m_mode   <= issue_id ? s1_mode   : s0_mode;
      end
   end

   // Latency pipe stage 0: a tagged entry on issue, otherwise a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid_reg[0] <= 1'b0;
      end else begin
         pipe_valid_reg[0] <= issue;
      end
      pipe_id_reg[0]  <= issue_id;
      pipe_tag_reg[0] <= issue_id ? s1_tag : s0_tag;
   end

   // Remaining latency pipe stages, one per multiplier latency edge.
   generate
      for (genvar gi = 1; gi < MULT_LAT; gi++) begin : g_pipe
         always_ff @(posedge clk) begin
            if (reset) begin
               pipe_valid_reg[gi] <= 1'b0;
            end else begin
               pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            end
            pipe_id_reg[gi]  <= pipe_id_reg[gi-1];
            pipe_tag_reg[gi] <= pipe_tag_reg[gi-1];
         end
      end
   endgenerate

   // Sample the multiplier outputs on the edge the pipe head says they belong to an op.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_valid_reg <= 1'b0;
      end else begin
         cap_valid_reg <= pipe_valid_reg[MULT_LAT-1];
      end
      if (pipe_valid_reg[MULT_LAT-1]) begin
         cap_entry_reg.id         <= pipe_id_reg[MULT_LAT-1];
         cap_entry_reg.tag        <= pipe_tag_reg[MULT_LAT-1];
         cap_entry_reg.data.res0  <= m_result_0;
         cap_entry_reg.data.res1  <= m_result_1;
         cap_entry_reg.data.carry <= m_result_carry;
      end
   end

   pirdsp_resp_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (resp_entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cap_valid_reg),
      .push_data (cap_entry_reg),
      .pop       (pop),
      .head      (head),
      .not_empty (r_valid),
      .count     (fifo_count)
   );

   assign r_id       = head.id;
   assign r_tag      = head.tag;
   assign r_result_0 = head.data.res0;
   assign r_result_1 = head.data.res1;
   assign r_carry    = head.data.carry;

   // Buffered responses can never outnumber the credits held.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (fifo_count <= inflight_reg);
      end
   end

endmodule
